// File: rtl/per2axi_req_channel.sv
// per2axi_req_channel
// Request path of the peripheral-to-AXI bridge. Captures one peripheral
// request at a time, rebases the cluster-local address into the global map,
// and issues it as a single-beat AXI read (AR) or write (AW + W). The
// companion response channel is told about every issued transaction and
// reports completion back through trans_r_valid_i.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transaction held; a request is granted and captured
// AR_SEND   | read address presented on AR until the slave accepts it
// WR_SEND   | AW and W presented independently until both are accepted
// WAIT_RESP | transaction issued; waiting for the response channel
module per2axi_req_channel #(
    parameter int unsigned PER_ADDR_WIDTH = 32,
    parameter int unsigned PER_ID_WIDTH   = 5,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH/8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [5:0]                cluster_id_i,

    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [PER_ID_WIDTH-1:0]   per_slave_id_i,
    output logic                      per_slave_gnt_o,

    output logic                      axi_master_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] axi_master_ar_addr_o,
    output logic [2:0]                axi_master_ar_prot_o,
    output logic [3:0]                axi_master_ar_region_o,
    output logic [7:0]                axi_master_ar_len_o,
    output logic [2:0]                axi_master_ar_size_o,
    output logic [1:0]                axi_master_ar_burst_o,
    output logic                      axi_master_ar_lock_o,
    output logic [3:0]                axi_master_ar_cache_o,
    output logic [3:0]                axi_master_ar_qos_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_master_ar_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_master_ar_user_o,
    input  logic                      axi_master_ar_ready_i,

    output logic                      axi_master_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] axi_master_aw_addr_o,
    output logic [2:0]                axi_master_aw_prot_o,
    output logic [3:0]                axi_master_aw_region_o,
    output logic [7:0]                axi_master_aw_len_o,
    output logic [2:0]                axi_master_aw_size_o,
    output logic [1:0]                axi_master_aw_burst_o,
    output logic                      axi_master_aw_lock_o,
    output logic [3:0]                axi_master_aw_cache_o,
    output logic [3:0]                axi_master_aw_qos_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_master_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0] axi_master_aw_user_o,
    input  logic                      axi_master_aw_ready_i,

    output logic                      axi_master_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] axi_master_w_data_o,
    output logic [AXI_STRB_WIDTH-1:0] axi_master_w_strb_o,
    output logic [AXI_USER_WIDTH-1:0] axi_master_w_user_o,
    output logic                      axi_master_w_last_o,
    input  logic                      axi_master_w_ready_i,

    output logic                      trans_req_o,
    output logic                      trans_we_o,
    output logic [PER_ID_WIDTH-1:0]   trans_id_o,
    output logic [AXI_ADDR_WIDTH-1:0] trans_add_o,
    input  logic                      trans_r_valid_i,

    output logic                      busy_o
);

    // Each cluster owns a 4 MiB window of the global address map.
    localparam logic [AXI_ADDR_WIDTH-1:0] CLUSTER_STRIDE = AXI_ADDR_WIDTH'(32'h0040_0000);

    typedef enum logic [1:0] {
        IDLE,
        AR_SEND,
        WR_SEND,
        WAIT_RESP
    } state_t;

    state_t                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_buf_addr;
    logic                      r_buf_we;
    logic [31:0]               r_buf_wdata;
    logic [3:0]                r_buf_be;
    logic [PER_ID_WIDTH-1:0]   r_buf_id;
    logic                      r_aw_done;
    logic                      r_w_done;

    logic [AXI_ADDR_WIDTH-1:0] w_glob_addr;
    logic                      w_ar_hs;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_aw_all;
    logic                      w_w_all;
    logic                      w_issue;

    // Global address wraps modulo the AXI address space.
    assign w_glob_addr = AXI_ADDR_WIDTH'(per_slave_add_i)
                       + AXI_ADDR_WIDTH'(cluster_id_i) * CLUSTER_STRIDE;

    assign per_slave_gnt_o = per_slave_req_i & (r_state == IDLE);
    assign busy_o          = (r_state != IDLE);

    // Valids decode straight from registered state, so reset drops them at once.
    assign axi_master_ar_valid_o = (r_state == AR_SEND);
    assign axi_master_aw_valid_o = (r_state == WR_SEND) & ~r_aw_done;
    assign axi_master_w_valid_o  = (r_state == WR_SEND) & ~r_w_done;

    assign w_ar_hs  = axi_master_ar_valid_o & axi_master_ar_ready_i;
    assign w_aw_hs  = axi_master_aw_valid_o & axi_master_aw_ready_i;
    assign w_w_hs   = axi_master_w_valid_o  & axi_master_w_ready_i;
    assign w_aw_all = r_aw_done | w_aw_hs;
    assign w_w_all  = r_w_done  | w_w_hs;
    assign w_issue  = w_ar_hs | ((r_state == WR_SEND) & w_aw_all & w_w_all);

    assign trans_req_o = w_issue;
    assign trans_we_o  = w_issue & r_buf_we;
    assign trans_id_o  = w_issue ? r_buf_id   : '0;
    assign trans_add_o = w_issue ? r_buf_addr : '0;

    // Payload comes only from the capture buffer, so it holds until handshake.
    assign axi_master_ar_addr_o = r_buf_addr;
    assign axi_master_ar_id_o   = AXI_ID_WIDTH'(r_buf_id);
    assign axi_master_aw_addr_o = r_buf_addr;
    assign axi_master_aw_id_o   = AXI_ID_WIDTH'(r_buf_id);
    assign axi_master_w_data_o  = {(AXI_DATA_WIDTH/32){r_buf_wdata}};
    assign axi_master_w_strb_o  = AXI_STRB_WIDTH'({4'b0000, r_buf_be}) << {r_buf_addr[2], 2'b00};
    assign axi_master_w_user_o  = '0;
    assign axi_master_w_last_o  = 1'b1;

    // Single-beat, 32-bit, INCR, unprivileged, non-cacheable accesses.
    assign axi_master_ar_prot_o   = 3'b000;
    assign axi_master_ar_region_o = 4'h0;
    assign axi_master_ar_len_o    = 8'h00;
    assign axi_master_ar_size_o   = 3'b010;
    assign axi_master_ar_burst_o  = 2'b01;
    assign axi_master_ar_lock_o   = 1'b0;
    assign axi_master_ar_cache_o  = 4'h0;
    assign axi_master_ar_qos_o    = 4'h0;
    assign axi_master_ar_user_o   = '0;
    assign axi_master_aw_prot_o   = 3'b000;
    assign axi_master_aw_region_o = 4'h0;
    assign axi_master_aw_len_o    = 8'h00;
    assign axi_master_aw_size_o   = 3'b010;
    assign axi_master_aw_burst_o  = 2'b01;
    assign axi_master_aw_lock_o   = 1'b0;
    assign axi_master_aw_cache_o  = 4'h0;
    assign axi_master_aw_qos_o    = 4'h0;
    assign axi_master_aw_user_o   = '0;

    // Request sequencing: capture, issue on AR or AW+W, wait for completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_buf_addr  <= '0;
            r_buf_we    <= 1'b0;
            r_buf_wdata <= '0;
            r_buf_be    <= '0;
            r_buf_id    <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (per_slave_req_i) begin
                        r_buf_addr  <= w_glob_addr;
                        r_buf_we    <= per_slave_we_i;
                        r_buf_wdata <= per_slave_wdata_i;
                        r_buf_be    <= per_slave_be_i;
                        r_buf_id    <= per_slave_id_i;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_state     <= per_slave_we_i ? AR_SEND : WR_SEND;
                    end
                end
                AR_SEND: begin
                    if (axi_master_ar_ready_i) begin
                        r_state <= WAIT_RESP;
                    end
                end
                WR_SEND: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_all && w_w_all) begin
                        r_state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (trans_r_valid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_per2axi_req_channel.sv
// Testbench for per2axi_req_channel: directed scenarios followed by random
// traffic, checked against a transaction-level model and a scoreboard queue.
`timescale 1ns/1ps
module tb_per2axi_req_channel;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [5:0]  cluster_id;
    logic        s_req, s_we, s_gnt;
    logic [31:0] s_add, s_wdata;
    logic [3:0]  s_be;
    logic [4:0]  s_id;

    logic        ar_valid, ar_ready, ar_lock;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot, ar_size;
    logic [3:0]  ar_region, ar_cache, ar_qos;
    logic [7:0]  ar_len;
    logic [1:0]  ar_burst;
    logic [5:0]  ar_id, ar_user;

    logic        aw_valid, aw_ready, aw_lock;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot, aw_size;
    logic [3:0]  aw_region, aw_cache, aw_qos;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic [5:0]  aw_id, aw_user;

    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic [5:0]  w_user;

    logic        trans_req, trans_we, trans_r_valid, busy;
    logic [4:0]  trans_id;
    logic [31:0] trans_add;

    always #5 clk_i = ~clk_i;

    per2axi_req_channel dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cluster_id_i(cluster_id),
        .per_slave_req_i(s_req), .per_slave_add_i(s_add), .per_slave_we_i(s_we),
        .per_slave_wdata_i(s_wdata), .per_slave_be_i(s_be), .per_slave_id_i(s_id),
        .per_slave_gnt_o(s_gnt),
        .axi_master_ar_valid_o(ar_valid), .axi_master_ar_addr_o(ar_addr),
        .axi_master_ar_prot_o(ar_prot), .axi_master_ar_region_o(ar_region),
        .axi_master_ar_len_o(ar_len), .axi_master_ar_size_o(ar_size),
        .axi_master_ar_burst_o(ar_burst), .axi_master_ar_lock_o(ar_lock),
        .axi_master_ar_cache_o(ar_cache), .axi_master_ar_qos_o(ar_qos),
        .axi_master_ar_id_o(ar_id), .axi_master_ar_user_o(ar_user),
        .axi_master_ar_ready_i(ar_ready),
        .axi_master_aw_valid_o(aw_valid), .axi_master_aw_addr_o(aw_addr),
        .axi_master_aw_prot_o(aw_prot), .axi_master_aw_region_o(aw_region),
        .axi_master_aw_len_o(aw_len), .axi_master_aw_size_o(aw_size),
        .axi_master_aw_burst_o(aw_burst), .axi_master_aw_lock_o(aw_lock),
        .axi_master_aw_cache_o(aw_cache), .axi_master_aw_qos_o(aw_qos),
        .axi_master_aw_id_o(aw_id), .axi_master_aw_user_o(aw_user),
        .axi_master_aw_ready_i(aw_ready),
        .axi_master_w_valid_o(w_valid), .axi_master_w_data_o(w_data),
        .axi_master_w_strb_o(w_strb), .axi_master_w_user_o(w_user),
        .axi_master_w_last_o(w_last), .axi_master_w_ready_i(w_ready),
        .trans_req_o(trans_req), .trans_we_o(trans_we), .trans_id_o(trans_id),
        .trans_add_o(trans_add), .trans_r_valid_i(trans_r_valid),
        .busy_o(busy)
    );

    typedef struct {
        logic        rd;
        logic [31:0] gaddr;
        logic [4:0]  id;
        logic [63:0] data;
        logic [7:0]  strb;
    } txn_t;

    txn_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    // Transaction-level model: at most one accepted request is outstanding.
    bit m_busy, m_issued, m_rd, m_aw_ok, m_w_ok;
    bit exp_gnt, exp_busy, exp_ar_v, exp_aw_v, exp_w_v, exp_treq;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got empty scoreboard expected a pending transaction (t=%0t)", nm, $time);
    endfunction

    function automatic logic [31:0] glob(input logic [5:0] c, input logic [31:0] a);
        longint unsigned s;
        s = 64'(a) + 64'(c) * 64'h40_0000;
        return s[31:0];
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] ga, input logic [3:0] b);
        logic [7:0] s;
        s = {4'h0, b};
        if ((ga % 8) >= 4) s = s << 4;
        return s;
    endfunction

    function automatic void compute_exp();
        bit pend;
        pend     = m_busy && !m_issued;
        exp_gnt  = rst_ni && s_req && !m_busy;
        exp_busy = m_busy;
        exp_ar_v = pend && m_rd;
        exp_aw_v = pend && !m_rd && !m_aw_ok;
        exp_w_v  = pend && !m_rd && !m_w_ok;
        exp_treq = pend && (m_rd ? ar_ready : ((m_aw_ok || aw_ready) && (m_w_ok || w_ready)));
    endfunction

    function automatic void model_update();
        txn_t t;
        if (!rst_ni) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (!m_issued) begin
                if (exp_treq) m_issued = 1'b1;
                if (aw_ready) m_aw_ok = 1'b1;
                if (w_ready)  m_w_ok  = 1'b1;
            end else if (trans_r_valid) begin
                m_busy = 1'b0;
            end
        end else if (s_req) begin
            m_busy   = 1'b1;
            m_issued = 1'b0;
            m_aw_ok  = 1'b0;
            m_w_ok   = 1'b0;
            m_rd     = s_we;
            t.rd     = s_we;
            t.gaddr  = glob(cluster_id, s_add);
            t.id     = s_id;
            t.data   = {s_wdata, s_wdata};
            t.strb   = lane(t.gaddr, s_be);
            sb_q.push_back(t);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 1'b0;
        sb_q.delete();
    endfunction

    function automatic void set_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] b, input logic [4:0] i);
        s_req = 1'b1; s_we = we; s_add = a; s_wdata = d; s_be = b; s_id = i;
    endfunction

    task automatic begin_cycle();
        compute_exp();
        @(negedge clk_i);
    endtask

    task automatic end_cycle();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic step();
        begin_cycle();
        end_cycle();
    endtask

    // Monitor: per-cycle control checks plus scoreboard payload checks.
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("gnt", s_gnt, exp_gnt);
            chk("busy", busy, exp_busy);
            chk("ar_valid", ar_valid, exp_ar_v);
            chk("aw_valid", aw_valid, exp_aw_v);
            chk("w_valid", w_valid, exp_w_v);
            chk("trans_req", trans_req, exp_treq);
            if (ar_valid) begin
                if (sb_q.size() == 0) fail_now("ar_payload");
                else begin
                    chk("ar_addr", ar_addr, sb_q[0].gaddr);
                    chk("ar_id", ar_id, 64'(sb_q[0].id));
                    chk("ar_attr", {ar_len, ar_size, ar_burst}, {8'd0, 3'b010, 2'b01});
                    chk("ar_zero", {ar_prot, ar_region, ar_lock, ar_cache, ar_qos, ar_user}, 64'd0);
                end
            end
            if (aw_valid) begin
                if (sb_q.size() == 0) fail_now("aw_payload");
                else begin
                    chk("aw_addr", aw_addr, sb_q[0].gaddr);
                    chk("aw_id", aw_id, 64'(sb_q[0].id));
                    chk("aw_attr", {aw_len, aw_size, aw_burst}, {8'd0, 3'b010, 2'b01});
                    chk("aw_zero", {aw_prot, aw_region, aw_lock, aw_cache, aw_qos, aw_user}, 64'd0);
                end
            end
            if (w_valid) begin
                if (sb_q.size() == 0) fail_now("w_payload");
                else begin
                    chk("w_data", w_data, sb_q[0].data);
                    chk("w_strb", w_strb, sb_q[0].strb);
                    chk("w_last_user", {w_last, w_user}, {1'b1, 6'd0});
                end
            end
            if (trans_req) begin
                if (sb_q.size() == 0) fail_now("trans_payload");
                else begin
                    chk("trans_we", trans_we, sb_q[0].rd);
                    chk("trans_id", trans_id, 64'(sb_q[0].id));
                    chk("trans_add", trans_add, sb_q[0].gaddr);
                    void'(sb_q.pop_front());
                end
            end else begin
                chk("trans_idle", {trans_we, trans_id, trans_add}, 64'd0);
            end
        end
    end

    initial begin
        rst_ni = 1'b0; cluster_id = '0;
        s_req = 1'b0; s_we = 1'b0; s_add = '0; s_wdata = '0; s_be = '0; s_id = '0;
        ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; trans_r_valid = 1'b0;
        model_reset();
        mon_en = 1'b1;
        repeat (2) step();
        rst_ni = 1'b1;
        step();

        // Read with cluster rebasing
        cluster_id = 6'd2;
        set_req(1'b1, 32'h1000_0010, 32'h0, 4'hF, 5'd5);
        ar_ready = 1'b1;
        begin_cycle(); chk("rd_gnt_same_cycle", s_gnt, 1'b1); end_cycle();
        s_req = 1'b0;
        begin_cycle();
        chk("rd_ar_addr_lit", ar_addr, 32'h1080_0010);
        chk("rd_ar_id_lit", ar_id, 6'd5);
        end_cycle();
        repeat (3) step();
        trans_r_valid = 1'b1; step(); trans_r_valid = 1'b0; step();

        // Write to the upper word lane, AW and W accepted together
        cluster_id = 6'd0;
        set_req(1'b0, 32'h0000_0014, 32'hDEAD_BEEF, 4'b0011, 5'd9);
        aw_ready = 1'b1; w_ready = 1'b1;
        step(); s_req = 1'b0;
        begin_cycle();
        chk("wr_data_lit", w_data, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("wr_strb_lit", w_strb, 8'h30);
        end_cycle();
        step(); trans_r_valid = 1'b1; step(); trans_r_valid = 1'b0;

        // Split write: AW at cycle 1, W only at cycle 4; stray completion ignored
        cluster_id = 6'd7;
        aw_ready = 1'b0; w_ready = 1'b0;
        set_req(1'b0, 32'h0000_0208, 32'h1234_5678, 4'b1010, 5'd17);
        step(); s_req = 1'b0;
        aw_ready = 1'b1; step(); aw_ready = 1'b0;
        trans_r_valid = 1'b1; step(); trans_r_valid = 1'b0;
        step();
        w_ready = 1'b1; step(); w_ready = 1'b0;
        step(); trans_r_valid = 1'b1; step(); trans_r_valid = 1'b0;

        // Back-pressure: request held through the whole transaction
        ar_ready = 1'b0;
        set_req(1'b1, 32'h0000_1000, 32'h0, 4'hF, 5'd3);
        step();
        set_req(1'b1, 32'h0000_2004, 32'h0, 4'hF, 5'd4);
        step(); ar_ready = 1'b1; step(); ar_ready = 1'b0;
        step(); step();
        trans_r_valid = 1'b1; step(); trans_r_valid = 1'b0;
        begin_cycle(); chk("bp_regrant", s_gnt, 1'b1); end_cycle();
        s_req = 1'b0; ar_ready = 1'b1;
        step(); step(); trans_r_valid = 1'b1; step(); trans_r_valid = 1'b0; step();

        // Address wrap in the top cluster
        cluster_id = 6'd63;
        set_req(1'b1, 32'hFFFF_FFF0, 32'h0, 4'hF, 5'd31);
        step(); s_req = 1'b0;
        begin_cycle(); chk("wrap_ar_addr_lit", ar_addr, 32'h0FBF_FFF0); end_cycle();
        trans_r_valid = 1'b1; step(); trans_r_valid = 1'b0;

        // Reset while W is still pending after the AW handshake
        cluster_id = 6'd1;
        ar_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        set_req(1'b0, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 5'd12);
        step(); s_req = 1'b0;
        aw_ready = 1'b1; step(); aw_ready = 1'b0;
        step();
        rst_ni = 1'b0; model_reset();
        #1;
        chk("rst_async_valids", {ar_valid, aw_valid, w_valid}, 3'b000);
        chk("rst_async_busy", busy, 1'b0);
        step(); step();
        rst_ni = 1'b1;
        set_req(1'b0, 32'h0000_0044, 32'h0BAD_CAFE, 4'b0110, 5'd13);
        aw_ready = 1'b1; w_ready = 1'b1;
        begin_cycle(); chk("rst_regrant", s_gnt, 1'b1); end_cycle();
        s_req = 1'b0;
        step(); trans_r_valid = 1'b1; step(); trans_r_valid = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) cluster_id = 6'($urandom_range(0, 63));
            s_req   = ($urandom_range(0, 99) < 45);
            s_we    = 1'($urandom_range(0, 1));
            s_add   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                                  : 32'($urandom);
            s_wdata = 32'($urandom);
            s_be    = 4'($urandom_range(0, 15));
            s_id    = 5'($urandom_range(0, 31));
            ar_ready = 1'($urandom_range(0, 1));
            aw_ready = 1'($urandom_range(0, 1));
            w_ready  = 1'($urandom_range(0, 1));
            trans_r_valid = ($urandom_range(0, 99) < 30);
            if (i == 1500) begin
                rst_ni = 1'b0; model_reset(); s_req = 1'b0;
                step(); step();
                rst_ni = 1'b1;
            end
            step();
        end

        // Drain whatever is outstanding
        s_req = 1'b0; ar_ready = 1'b1; aw_ready = 1'b1; w_ready = 1'b1; trans_r_valid = 1'b0;
        repeat (2) step();
        trans_r_valid = 1'b1;
        repeat (2) step();
        trans_r_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
